// File: rtl/register_unit_sb.sv
// register_unit_sb: 2-read/1-write register unit with a per-register
// pending-write scoreboard for the pipelined core.
//
// Decode side : rs1/rs2 read addresses, RUrs1/RUrs2 read data (combinational),
//               rs1_busy/rs2_busy hazard flags, iss_valid/iss_rd issue port.
// Writeback   : RUWr/rd/RUDataWr write port; each write also retires one
//               pending writer of rd.
// Status      : sb_err, sticky counter overflow/underflow flag.
// Clock/reset : clk rising edge, rst_n asynchronous active-low.
//
// Build option: define REGFILE_BYPASS_EN to forward the writeback data and
// retire into the same-cycle read/busy outputs.

// One pending-write counter. Saturates at both ends and reports the
// attempted overflow/underflow on err (combinational, same cycle).
module sb_counter #(
    parameter int SB_BITS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               dec,
    output logic [SB_BITS-1:0] cnt,
    output logic               err
);
    localparam logic [SB_BITS-1:0] CMAX = '1;

    logic up, dn;
    assign up  = inc && !dec;
    assign dn  = dec && !inc;
    assign err = (up && cnt == CMAX) || (dn && cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt <= '0;
        else if (up && cnt != CMAX)  cnt <= cnt + SB_BITS'(1);
        else if (dn && cnt != '0)    cnt <= cnt - SB_BITS'(1);
    end
endmodule

module register_unit_sb #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int SP_IDX  = 2,
    parameter int SP_INIT = 1000,
    parameter int SB_BITS = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] RUrs1,
    output logic [XLEN-1:0] RUrs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            RUWr,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] RUDataWr,
    output logic            sb_err
);
    localparam logic [XLEN-1:0] SP_VAL = XLEN'(SP_INIT);

    logic [NREGS-1:0][XLEN-1:0]    regs;
    logic [NREGS-1:0][SB_BITS-1:0] cnt;
    logic [NREGS-1:0]              err;
    logic                          wr_en;

    assign wr_en = RUWr && rd != '0;

    // ---------------- register array ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == SP_IDX) ? SP_VAL : '0;
        end else if (wr_en) begin
            regs[rd] <= RUDataWr;
        end
    end

    // ---------------- scoreboard ----------------
    // x0 never has a writer, so its counter slot is tied off.
    assign cnt[0] = '0;
    assign err[0] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_sb
        sb_counter #(.SB_BITS(SB_BITS)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (iss_valid && iss_rd == AW'(i)),
            .dec   (wr_en && rd == AW'(i)),
            .cnt   (cnt[i]),
            .err   (err[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    sb_err <= 1'b0;
        else if (|err) sb_err <= 1'b1;
    end

    // ---------------- read ports ----------------
`ifdef REGFILE_BYPASS_EN
    // A retire this cycle clears busy only when it is the last writer and
    // no new writer of the same register issues alongside it.
    logic last1, last2;
    assign last1 = wr_en && rd == rs1 && cnt[rs1] == SB_BITS'(1)
                   && !(iss_valid && iss_rd == rs1);
    assign last2 = wr_en && rd == rs2 && cnt[rs2] == SB_BITS'(1)
                   && !(iss_valid && iss_rd == rs2);
`endif

    always_comb begin
        RUrs1    = (rs1 == '0) ? '0 : regs[rs1];
        RUrs2    = (rs2 == '0) ? '0 : regs[rs2];
        rs1_busy = cnt[rs1] != '0;
        rs2_busy = cnt[rs2] != '0;
`ifdef REGFILE_BYPASS_EN
        // wr_en excludes rd==0, so x0 can never be forwarded.
        if (wr_en && rd == rs1) RUrs1 = RUDataWr;
        if (wr_en && rd == rs2) RUrs2 = RUDataWr;
        if (last1) rs1_busy = 1'b0;
        if (last2) rs2_busy = 1'b0;
`endif
    end
endmodule

// File: tb/tb_register_unit_sb.sv
module tb_register_unit_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int CMAX  = 3;

    logic            clk, rst_n;
    logic [AW-1:0]   rs1, rs2, iss_rd, rd;
    logic [XLEN-1:0] RUrs1, RUrs2, RUDataWr;
    logic            rs1_busy, rs2_busy, iss_valid, RUWr, sb_err;

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    register_unit_sb dut (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .RUrs1(RUrs1), .RUrs2(RUrs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .RUWr(RUWr), .rd(rd),
        .RUDataWr(RUDataWr), .sb_err(sb_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_reg [NREGS];
    int              m_cnt [NREGS];
    bit              m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                m_reg[i] <= (i == 2) ? 32'd1000 : 32'd0;
                m_cnt[i] <= 0;
            end
            m_err <= 0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (iss_valid && iss_rd == i && !(RUWr && rd == i)) begin
                    if (m_cnt[i] == CMAX) m_err <= 1;
                    else                  m_cnt[i] <= m_cnt[i] + 1;
                end else if (RUWr && rd == i && !(iss_valid && iss_rd == i)) begin
                    if (m_cnt[i] == 0) m_err <= 1;
                    else               m_cnt[i] <= m_cnt[i] - 1;
                end
            end
            if (RUWr && rd != 0) m_reg[rd] <= RUDataWr;
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input int rs);
        logic [XLEN-1:0] v;
        v = (rs == 0) ? '0 : m_reg[rs];
`ifdef REGFILE_BYPASS_EN
        if (RUWr && rd != 0 && rd == rs) v = RUDataWr;
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input int rs);
        logic b;
        b = (rs != 0) && (m_cnt[rs] != 0);
`ifdef REGFILE_BYPASS_EN
        if (m_cnt[rs] == 1 && RUWr && rd != 0 && rd == rs && !(iss_valid && iss_rd == rs))
            b = 0;
`endif
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            chk("cmp_RUrs1", RUrs1, exp_data(int'(rs1)));
            chk("cmp_RUrs2", RUrs2, exp_data(int'(rs2)));
            chk("cmp_rs1_busy", {31'd0, rs1_busy}, {31'd0, exp_busy(int'(rs1))});
            chk("cmp_rs2_busy", {31'd0, rs2_busy}, {31'd0, exp_busy(int'(rs2))});
            chk("cmp_sb_err", {31'd0, sb_err}, {31'd0, m_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic iv, input logic [AW-1:0] ird, input logic wr,
                         input logic [AW-1:0] wrd, input logic [31:0] wd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        iss_valid = iv; iss_rd = ird; RUWr = wr; rd = wrd; RUDataWr = wd;
        rs1 = r1; rs2 = r2;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3 rst_n = 0;
        #19 rst_n = 1;
        tick();
        check_en = 1;

        // Reset values
        drive(0, 0, 0, 0, 0, 2, 5);
        mid();
        chk("rst_RUrs1", RUrs1, 32'd1000);
        chk("rst_RUrs2", RUrs2, 32'd0);
        chk("rst_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
        chk("rst_sb_err", {31'd0, sb_err}, 32'd0);

        // x0 protection
        tick();
        drive(1, 0, 1, 0, 32'hDEADBEEF, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        mid();
        chk("x0_data", RUrs1, 32'd0);
        chk("x0_busy", {31'd0, rs1_busy}, 32'd0);
        chk("x0_sb_err", {31'd0, sb_err}, 32'd0);

        // Three issues to x7
        for (int k = 0; k < 3; k++) begin
            tick();
            drive(1, 7, 0, 0, 0, 7, 0);
        end
        tick();
        drive(0, 0, 0, 0, 0, 7, 0);
        mid();
        chk("sb3_busy", {31'd0, rs1_busy}, 32'd1);
        chk("sb3_model_cnt", m_cnt[7], 32'd3);
        chk("sb3_sb_err", {31'd0, sb_err}, 32'd0);

        // Fourth issue overflows
        tick();
        drive(1, 7, 0, 0, 0, 7, 0);
        tick();
        drive(0, 0, 0, 0, 0, 7, 0);
        mid();
        chk("ovf_sb_err", {31'd0, sb_err}, 32'd1);
        chk("ovf_busy", {31'd0, rs1_busy}, 32'd1);
        chk("ovf_model_cnt", m_cnt[7], 32'd3);

        // Three retires
        for (int k = 1; k <= 3; k++) begin
            tick();
            drive(0, 0, 1, 7, 32'h100 + k, 7, 0);
        end
        tick();
        drive(0, 0, 0, 0, 0, 7, 0);
        mid();
        chk("ret_busy", {31'd0, rs1_busy}, 32'd0);
        chk("ret_data", RUrs1, 32'h103);
        chk("ret_sb_err_sticky", {31'd0, sb_err}, 32'd1);

        // Reset mid-operation discards pending writers and error
        tick();
        drive(1, 5, 0, 0, 0, 5, 7);
        tick();
        drive(0, 0, 0, 0, 0, 5, 7);
        #2 rst_n = 0;
        #1;
        chk("rst2_busy", {31'd0, rs1_busy}, 32'd0);
        chk("rst2_sb_err", {31'd0, sb_err}, 32'd0);
        chk("rst2_x7", RUrs2, 32'd0);
        #4 rst_n = 1;

        // Issue and retire together at cnt==0: no error, data written
        tick();
        drive(1, 10, 1, 10, 32'h77, 10, 0);
        tick();
        drive(0, 0, 0, 0, 0, 10, 0);
        mid();
        chk("id0_sb_err", {31'd0, sb_err}, 32'd0);
        chk("id0_data", RUrs1, 32'h77);
        chk("id0_busy", {31'd0, rs1_busy}, 32'd0);

        // Issue and retire together on x9 with cnt==1
        tick();
        drive(1, 9, 0, 0, 0, 9, 0);
        tick();
        drive(1, 9, 1, 9, 32'h12345678, 9, 0);
        tick();
        drive(0, 0, 0, 0, 0, 9, 0);
        mid();
        chk("id1_busy", {31'd0, rs1_busy}, 32'd1);
        chk("id1_data", RUrs1, 32'h12345678);
        chk("id1_sb_err", {31'd0, sb_err}, 32'd0);
        chk("id1_model_cnt", m_cnt[9], 32'd1);

        // Untracked write: underflow but data lands
        tick();
        drive(0, 0, 1, 4, 32'h55, 4, 0);
        tick();
        drive(0, 0, 0, 0, 0, 4, 0);
        mid();
        chk("unf_data", RUrs1, 32'h55);
        chk("unf_sb_err", {31'd0, sb_err}, 32'd1);

        // Write-to-read on x3 with one pending writer
        tick();
        drive(1, 3, 0, 0, 0, 0, 3);
        tick();
        drive(0, 0, 1, 3, 32'hA5A5A5A5, 0, 3);
        mid();
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_data", RUrs2, 32'hA5A5A5A5);
        chk("byp_same_busy", {31'd0, rs2_busy}, 32'd0);
`else
        chk("byp_same_data", RUrs2, 32'd0);
        chk("byp_same_busy", {31'd0, rs2_busy}, 32'd1);
`endif
        tick();
        drive(0, 0, 0, 0, 0, 0, 3);
        mid();
        chk("byp_next_data", RUrs2, 32'hA5A5A5A5);
        chk("byp_next_busy", {31'd0, rs2_busy}, 32'd0);

        tick();
        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
